// File: rtl/stretch_pkg.sv
// Shared widths, pipeline depth and gain-FSM state encoding for the contrast stretch block.
package stretch_pkg;

    localparam int PIX_W    = 8;
    localparam int FRAC_W   = 16;
    localparam int KW       = PIX_W + FRAC_W;
    localparam int PW       = 2 * PIX_W + FRAC_W;
    localparam int PIPE_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } gain_state_t;

endpackage

// File: rtl/recip_div.sv
// Serial restoring divider: one quotient bit per clock, KW clocks per divide.
// Asserting start at any time (re)loads the operands.
module recip_div
    import stretch_pkg::*;
#(
    parameter int DW = PIX_W,
    parameter int KW = PIX_W + FRAC_W
) (
    input  logic          pixelclk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [KW-1:0] num,
    input  logic [DW-1:0] den,
    output logic          busy,
    output logic          done,
    output logic [KW-1:0] quo
);

    localparam int CW = $clog2(KW + 1);

    logic [DW-1:0] r_rem;
    logic [KW-1:0] r_quo;
    logic [DW-1:0] r_den;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [DW:0]   w_trial;
    logic [DW:0]   w_sub;
    logic          w_ge;

    // The remainder is always below den, so DW+1 bits hold the shifted trial value.
    assign w_trial = {r_rem, r_quo[KW-1]};
    assign w_sub   = w_trial - {1'b0, r_den};
    assign w_ge    = (w_trial >= {1'b0, r_den});

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_cnt  <= CW'(KW);
        end else if (r_busy) begin
            r_cnt  <= r_cnt - CW'(1);
            r_busy <= (r_cnt != CW'(1));
            r_done <= (r_cnt == CW'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    always_ff @(posedge pixelclk) begin
        if (start) begin
            r_rem <= '0;
            r_quo <= num;
            r_den <= den;
        end else if (r_busy) begin
            r_rem <= w_ge ? w_sub[DW-1:0] : w_trial[DW-1:0];
            r_quo <= {r_quo[KW-2:0], w_ge};
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign quo  = r_quo;

endmodule

// File: rtl/contrast_stretch.sv
// Linear contrast stretch: gain computed from previous-frame min/max during blanking, applied via a 3-stage pipeline.
// Build option STRETCH_ROUND_EN selects round-to-nearest instead of truncation in the final scaling stage.
module contrast_stretch
    import stretch_pkg::*;
#(
    parameter int DW = PIX_W,
    parameter int RW = FRAC_W
) (
    input  logic          pixelclk,
    input  logic          reset_n,
    input  logic [DW-1:0] din,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic          i_de,
    input  logic [DW-1:0] gray_max,
    input  logic [DW-1:0] gray_min,
    output logic [DW-1:0] dout,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic          stale
);

    localparam int KB = DW + RW;
    localparam int PB = 2 * DW + RW;
    localparam int QB = PB - RW;
    localparam logic [DW-1:0] PIX_MAX = '1;
    localparam logic [KB-1:0] NUM     = {PIX_MAX, {RW{1'b0}}};

    gain_state_t   r_state, w_next;
    logic          r_vsync_d, w_vs_rise, w_vs_fall;
    logic          r_wait_cnt, w_snap, w_div_start, w_div_fin;
    logic [DW:0]   w_range;
    logic          w_range_ok;
    logic          w_div_busy, w_div_done;
    logic [KB-1:0] w_div_quo;
    logic [KB-1:0] r_pend_k, r_act_k;
    logic [DW-1:0] r_pend_min, r_pend_max, r_act_min, r_act_max;
    logic          r_pend_valid, r_act_valid, r_stale;
    logic [DW-1:0] w_d;
    logic [DW-1:0] r_d_p0, r_din_p0, r_din_p1, r_dout_p2;
    logic [KB-1:0] r_k_p0;
    logic [PB-1:0] r_prod_p1;
    logic          r_byp_p0, r_byp_p1;
    logic [2:0]    r_sync_p0, r_sync_p1, r_sync_p2;

    function automatic logic [DW-1:0] scale_sat(input logic [PB-1:0] p);
        logic [PB-1:0] t;
        logic [QB-1:0] q;
`ifdef STRETCH_ROUND_EN
        t = p + {{(PB-RW){1'b0}}, 1'b1, {(RW-1){1'b0}}};
`else
        t = p;
`endif
        q = t[PB-1:RW];
        if (q > {{(QB-DW){1'b0}}, PIX_MAX})
            return PIX_MAX;
        return q[DW-1:0];
    endfunction

    assign w_vs_rise  = i_vsync & ~r_vsync_d;
    assign w_vs_fall  = ~i_vsync & r_vsync_d;
    assign w_range    = {1'b0, gray_max} - {1'b0, gray_min};
    assign w_range_ok = ~w_range[DW] && (w_range != '0);

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync_d  <= 1'b0;
            r_state    <= ST_IDLE;
            r_wait_cnt <= 1'b0;
        end else begin
            r_vsync_d  <= i_vsync;
            r_state    <= w_next;
            r_wait_cnt <= (r_state == ST_WAIT) && !w_vs_fall && !r_wait_cnt;
        end
    end

    // A vsync rise always aborts; a vsync fall always restarts the settle window.
    always_comb begin
        w_next = r_state;
        if (w_vs_rise) begin
            w_next = ST_IDLE;
        end else if (w_vs_fall) begin
            w_next = ST_WAIT;
        end else begin
            case (r_state)
                ST_WAIT: if (r_wait_cnt) w_next = w_range_ok ? ST_DIV : ST_DONE;
                ST_DIV:  if (w_div_done && !w_div_busy) w_next = ST_DONE;
                ST_DONE: w_next = ST_IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_snap      = (r_state == ST_WAIT) && r_wait_cnt && !w_vs_rise && !w_vs_fall;
        w_div_start = w_snap && w_range_ok;
        w_div_fin   = (r_state == ST_DIV) && w_div_done && !w_div_busy && !w_vs_rise && !w_vs_fall;
    end

    recip_div #(.DW(DW), .KW(KB)) u_div (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .start    (w_div_start),
        .num      (NUM),
        .den      (w_range[DW-1:0]),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quo      (w_div_quo)
    );

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid <= 1'b0;
            r_act_valid  <= 1'b0;
            r_stale      <= 1'b0;
        end else begin
            if (w_snap)
                r_pend_valid <= 1'b0;
            else if (w_div_fin)
                r_pend_valid <= 1'b1;
            if (w_vs_rise) begin
                if (r_state == ST_IDLE)
                    r_act_valid <= r_pend_valid;
                r_stale <= (r_state != ST_IDLE);
            end
        end
    end

    always_ff @(posedge pixelclk) begin
        if (w_snap) begin
            r_pend_min <= gray_min;
            r_pend_max <= gray_max;
        end
        if (w_div_fin)
            r_pend_k <= w_div_quo;
        if (w_vs_rise && (r_state == ST_IDLE)) begin
            r_act_k   <= r_pend_k;
            r_act_min <= r_pend_min;
            r_act_max <= r_pend_max;
        end
    end

    always_comb begin
        w_d = '0;
        if (din < r_act_min)
            w_d = '0;
        else if (din > r_act_max)
            w_d = r_act_max - r_act_min;
        else
            w_d = din - r_act_min;
    end

    // Stage 0: clamp and offset; gain travels with the sample
    always_ff @(posedge pixelclk) begin
        r_d_p0   <= w_d;
        r_din_p0 <= din;
        r_k_p0   <= r_act_k;
    end

    // Stage 1: multiply by fixed-point gain
    always_ff @(posedge pixelclk) begin
        r_prod_p1 <= {{(PB-DW){1'b0}}, r_d_p0} * {{(PB-KB){1'b0}}, r_k_p0};
        r_din_p1  <= r_din_p0;
    end

    // Stage 2: scale, saturate or bypass; syncs realigned with the data
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_byp_p0  <= 1'b1;
            r_byp_p1  <= 1'b1;
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_sync_p2 <= '0;
            r_dout_p2 <= '0;
        end else begin
            r_byp_p0  <= ~r_act_valid;
            r_byp_p1  <= r_byp_p0;
            r_sync_p0 <= {i_hsync, i_vsync, i_de};
            r_sync_p1 <= r_sync_p0;
            r_sync_p2 <= r_sync_p1;
            r_dout_p2 <= r_byp_p1 ? r_din_p1 : scale_sat(r_prod_p1);
        end
    end

    assign dout    = r_dout_p2;
    assign o_hsync = r_sync_p2[2];
    assign o_vsync = r_sync_p2[1];
    assign o_de    = r_sync_p2[0];
    assign stale   = r_stale;

endmodule
